// File: rtl/trap_controller.sv
// trap_controller
//   Trap sequencer for an RV32 core. Picks the highest-priority synchronous
//   exception, flushes and stalls the pipeline, records mepc/mcause/mtval,
//   and then redirects fetch to mtvec. It also sequences mret returns and
//   halts the core if a trap arrives while a handler is already running.
//
// Ports
//   clk, rst_n         core clock, synchronous active-low reset
//   exc_valid[3:0]     exception requests: 0 fetch misaligned, 1 illegal,
//                      2 ecall, 3 load misaligned
//   exc_pc, exc_tval   faulting PC and trap value
//   mret               mret retiring this cycle
//   mtvec_we/_wdata    mtvec write port, accepted in every state
//   stall, flush       pipeline hold / kill
//   redirect_valid/pc  one-cycle fetch redirect; pc holds between strobes
//   mepc, mcause,      trap CSRs
//   mtval, mtvec
//   in_trap            handler running
//   double_fault       sticky halt indication
module trap_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] HANDLER_ADDR = 32'h00000004,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            mtvec_we,
  input  logic [XLEN-1:0] mtvec_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [XLEN-1:0] mtvec,
  output logic            in_trap,
  output logic            double_fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SAVE,
    ST_REDIRECT,
    ST_RETURN,
    ST_HALT
  } state_t;

  localparam logic [XLEN-1:0] MTVEC_RESET = {HANDLER_ADDR[XLEN-1:2], 2'b00};
  localparam logic [3:0]      FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [3:0]      pend_cause_reg;
  logic [XLEN-1:0] pend_pc_reg;
  logic [XLEN-1:0] pend_tval_reg;

  logic [3:0]      win_onehot;
  logic [3:0]      win_cause;
  logic [XLEN-1:0] mtvec_wmask;
  logic [XLEN-1:0] mtvec_next;

  // Lowest set request bit wins; every higher bit is masked off.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign win_onehot[gi] = exc_valid[gi];
      end else begin : g_rest
        assign win_onehot[gi] = exc_valid[gi] & ~(|exc_valid[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    win_cause = 4'd0;
    if (win_onehot[1]) win_cause = 4'd2;
    if (win_onehot[2]) win_cause = 4'd11;
    if (win_onehot[3]) win_cause = 4'd4;
  end

  assign mtvec_wmask = {mtvec_wdata[XLEN-1:2], 2'b00};
  // A write landing in the SAVE cycle must already steer the redirect.
  assign mtvec_next  = mtvec_we ? mtvec_wmask : mtvec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 4'd0;
      pend_cause_reg <= 4'd0;
      pend_pc_reg    <= '0;
      pend_tval_reg  <= '0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mtvec          <= MTVEC_RESET;
      in_trap        <= 1'b0;
      double_fault   <= 1'b0;
    end else begin
      mtvec          <= mtvec_next;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|exc_valid) begin
            stall <= 1'b1;
            if (in_trap) begin
              double_fault <= 1'b1;
              state_reg    <= ST_HALT;
            end else begin
              pend_cause_reg <= win_cause;
              pend_pc_reg    <= exc_pc;
              pend_tval_reg  <= exc_tval;
              cnt_reg        <= FLUSH_LOAD;
              flush          <= 1'b1;
              state_reg      <= ST_FLUSH;
            end
          end else if (mret) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            flush          <= 1'b1;
            stall          <= 1'b1;
            state_reg      <= ST_RETURN;
          end
        end
        ST_FLUSH: begin
          // flush was raised on entry, so the counter starts at N-1 and
          // the last flush cycle is the one where it reads zero.
          stall <= 1'b1;
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_SAVE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
            flush   <= 1'b1;
          end
        end
        ST_SAVE: begin
          mepc           <= {pend_pc_reg[XLEN-1:2], 2'b00};
          mcause         <= {{(XLEN-4){1'b0}}, pend_cause_reg};
          mtval          <= pend_tval_reg;
          in_trap        <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= mtvec_next;
          stall          <= 1'b1;
          state_reg      <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          state_reg <= ST_IDLE;
        end
        ST_RETURN: begin
          in_trap   <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_HALT: begin
          stall <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  exc_valid;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, mtvec_we;
  logic [31:0] mtvec_wdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc, mepc, mcause, mtval, mtvec;
  logic        in_trap, double_fault;

  int checks = 0;
  int fails  = 0;

  // Architectural model of the visible CSR / status state.
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_rpc;
  logic        m_in_trap;

  trap_controller #(.XLEN(32), .HANDLER_ADDR(32'h00000004), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .mret(mret), .mtvec_we(mtvec_we),
    .mtvec_wdata(mtvec_wdata), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mepc(mepc), .mcause(mcause), .mtval(mtval), .mtvec(mtvec),
    .in_trap(in_trap), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cause_of(input logic [3:0] ev);
    int codes [4] = '{0, 2, 11, 4};
    for (int b = 0; b < 4; b++)
      if (ev[b]) return 32'(codes[b]);
    return 32'hdead;
  endfunction

  function automatic void model_reset;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0;
    m_mtvec = 32'h00000004; m_in_trap = 1'b0;
  endfunction

  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_reset();
    checks++;
    if ({stall, flush, redirect_valid, in_trap, double_fault} !== 5'b0) begin
      fails++; $display("FAIL %s_ctrl got %b want 00000", tag, {stall, flush, redirect_valid, in_trap, double_fault});
    end
    checks++;
    if ({redirect_pc, mepc, mcause, mtval} !== 128'b0) begin
      fails++; $display("FAIL %s_csr got rpc=%h mepc=%h mcause=%h mtval=%h want all 0", tag, redirect_pc, mepc, mcause, mtval);
    end
    checks++;
    if (mtvec !== 32'h00000004) begin
      fails++; $display("FAIL %s_mtvec got %h want 00000004", tag, mtvec);
    end
    $display("reset %s: outputs cleared, mtvec=%h", tag, mtvec);
  endtask

  // One full trap sequence. Optional noise on exc_valid/mret while the
  // sequence runs must be ignored; optional mtvec write in the SAVE cycle.
  task automatic test_trap(input logic [3:0] ev, input logic [31:0] pc, input logic [31:0] tval,
                           input bit with_mret, input bit save_wr, input logic [31:0] save_wd,
                           input bit noise);
    logic [31:0] cause = cause_of(ev);
    exc_valid = ev; exc_pc = pc; exc_tval = tval; mret = with_mret;
    tick;
    exc_valid = 0; mret = 0; exc_pc = $urandom; exc_tval = $urandom;
    for (int k = 1; k <= FC; k++) begin
      if (noise) begin exc_valid = 4'($urandom); mret = 1'($urandom); end
      checks++;
      if ({flush, stall, redirect_valid} !== 3'b110) begin
        fails++; $display("FAIL trap_flush%0d got fsr=%b want 110", k, {flush, stall, redirect_valid});
      end
      tick;
    end
    if (noise) begin exc_valid = 4'($urandom); mret = 1'($urandom); end
    if (save_wr) begin
      mtvec_we = 1'b1; mtvec_wdata = save_wd; m_mtvec = {save_wd[31:2], 2'b00};
    end
    checks++;
    if ({flush, stall, redirect_valid} !== 3'b010) begin
      fails++; $display("FAIL trap_save got fsr=%b want 010", {flush, stall, redirect_valid});
    end
    checks++;
    if (mcause !== m_mcause) begin
      fails++; $display("FAIL trap_csr_early got mcause=%h want %h", mcause, m_mcause);
    end
    tick;
    mtvec_we = 1'b0;
    m_mepc = {pc[31:2], 2'b00}; m_mcause = cause; m_mtval = tval;
    m_in_trap = 1'b1; m_rpc = m_mtvec;
    checks++;
    if ({flush, stall, redirect_valid} !== 3'b011) begin
      fails++; $display("FAIL trap_redirect got fsr=%b want 011", {flush, stall, redirect_valid});
    end
    checks++;
    if (redirect_pc !== m_rpc) begin
      fails++; $display("FAIL trap_rpc got %h want %h", redirect_pc, m_rpc);
    end
    checks++;
    if ({mepc, mcause, mtval, mtvec, in_trap} !== {m_mepc, m_mcause, m_mtval, m_mtvec, 1'b1}) begin
      fails++; $display("FAIL trap_csr got mepc=%h mcause=%h mtval=%h mtvec=%h in_trap=%b want %h %h %h %h 1",
                        mepc, mcause, mtval, mtvec, in_trap, m_mepc, m_mcause, m_mtval, m_mtvec);
    end
    tick;
    exc_valid = 0; mret = 0;
    checks++;
    if ({flush, stall, redirect_valid, redirect_pc} !== {3'b000, m_rpc}) begin
      fails++; $display("FAIL trap_idle got fsr=%b rpc=%h want 000 %h", {flush, stall, redirect_valid}, redirect_pc, m_rpc);
    end
    $display("trap ev=%b pc=%h tval=%h mret=%0d -> mcause=%0d mepc=%h redirect=%h", ev, pc, tval, with_mret, m_mcause, m_mepc, m_rpc);
  endtask

  task automatic test_return;
    logic it = m_in_trap;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    m_rpc = m_mepc;
    checks++;
    if ({flush, stall, redirect_valid, redirect_pc, in_trap} !== {3'b111, m_rpc, it}) begin
      fails++; $display("FAIL ret_redirect got fsr=%b rpc=%h in_trap=%b want 111 %h %b", {flush, stall, redirect_valid}, redirect_pc, in_trap, m_rpc, it);
    end
    tick;
    m_in_trap = 1'b0;
    checks++;
    if ({flush, stall, redirect_valid, redirect_pc, in_trap} !== {3'b000, m_rpc, 1'b0}) begin
      fails++; $display("FAIL ret_done got fsr=%b rpc=%h in_trap=%b want 000 %h 0", {flush, stall, redirect_valid}, redirect_pc, in_trap, m_rpc);
    end
    $display("mret -> redirect %h, in_trap cleared", m_rpc);
  endtask

  task automatic test_mtvec(input logic [31:0] wd);
    mtvec_we = 1'b1; mtvec_wdata = wd;
    tick;
    mtvec_we = 1'b0;
    m_mtvec = {wd[31:2], 2'b00};
    checks++;
    if ({mtvec, stall, flush} !== {m_mtvec, 2'b00}) begin
      fails++; $display("FAIL mtvec_write got %h stall=%b flush=%b want %h 0 0", mtvec, stall, flush, m_mtvec);
    end
    $display("mtvec write %h -> %h", wd, m_mtvec);
  endtask

  task automatic test_double_fault;
    exc_valid = 4'b0100;
    tick;
    exc_valid = 0;
    checks++;
    if ({double_fault, stall, flush, redirect_valid} !== 4'b1100) begin
      fails++; $display("FAIL df_enter got df,s,f,rv=%b want 1100", {double_fault, stall, flush, redirect_valid});
    end
    checks++;
    if ({mepc, mcause, mtval} !== {m_mepc, m_mcause, m_mtval}) begin
      fails++; $display("FAIL df_csr got mepc=%h mcause=%h mtval=%h want %h %h %h", mepc, mcause, mtval, m_mepc, m_mcause, m_mtval);
    end
    for (int i = 0; i < 8; i++) begin
      exc_valid = 4'($urandom); mret = 1'($urandom);
      tick;
      checks++;
      if ({double_fault, stall, flush, redirect_valid, in_trap} !== 5'b11001) begin
        fails++; $display("FAIL df_hold%0d got df,s,f,rv,it=%b want 11001", i, {double_fault, stall, flush, redirect_valid, in_trap});
      end
    end
    exc_valid = 0; mret = 0;
    $display("double fault: halted, mcause=%0d kept", m_mcause);
    test_reset("after_df");
  endtask

  task automatic test_mid_reset;
    test_mtvec(32'h0000abcd);
    exc_valid = 4'b0010; exc_pc = 32'h200; exc_tval = 32'h13;
    tick;
    exc_valid = 0;
    checks++;
    if ({flush, stall} !== 2'b11) begin
      fails++; $display("FAIL midrst_flush got fs=%b want 11", {flush, stall});
    end
    test_reset("mid_flush");
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      int op = $urandom_range(0, 9);
      if (op < 2) test_mtvec($urandom);
      else if (m_in_trap || op == 2) test_return;
      else test_trap(4'($urandom_range(1, 15)), $urandom, $urandom, 1'($urandom),
                     $urandom_range(0, 3) == 0, $urandom, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; exc_valid = 0; exc_pc = 0; exc_tval = 0;
    mret = 0; mtvec_we = 0; mtvec_wdata = 0;
    model_reset();
    tick;
    test_reset("power_on");
    test_trap(4'b0001, 32'h00000102, 32'h00000102, 1'b0, 1'b0, 32'h0, 1'b0);
    test_return;
    test_trap(4'b1110, 32'h00000040, 32'h00000777, 1'b0, 1'b0, 32'h0, 1'b0);
    test_double_fault;
    test_mtvec(32'h00001003);
    test_trap(4'b0100, 32'h00000300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    test_return;
    test_trap(4'b0010, 32'h00000404, 32'hcafe0001, 1'b1, 1'b0, 32'h0, 1'b0);
    test_return;
    test_trap(4'b1000, 32'h00000503, 32'h00000abc, 1'b0, 1'b1, 32'h00002002, 1'b1);
    test_return;
    test_mid_reset;
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
